// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the ALU issue front-end.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

  // Commands that bypass the ALU and answer with an error response.
  function automatic logic cmd_err(input logic [3:0] op, input logic [15:0] b);
    return (op != OP_ADD && op != OP_SUB && op != OP_MUL && op != OP_DIV) ||
           (op == OP_DIV && b == 16'd0);
  endfunction

endpackage

// File: rtl/enhanced_ALU.sv
// Combinational 16-bit signed ALU: ADD/SUB/MUL/DIV with 32-bit result and status flags.
import alu_pkg::*;

module enhanced_ALU (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  operation,
  output logic [31:0] Result,
  output logic [15:0] Remainder,
  output logic        Z,
  output logic        N,
  output logic        C,
  output logic        V,
  output logic        C_out
);

  logic signed [31:0] sa, sb;
  logic        [16:0] ucarry;

  assign sa     = {{16{A[15]}}, A};
  assign sb     = {{16{B[15]}}, B};
  assign ucarry = {1'b0, A} + {1'b0, B};

  always_comb begin
    Result    = 32'd0;
    Remainder = 16'd0;
    C         = 1'b0;
    V         = 1'b0;
    unique case (operation)
      OP_ADD: begin
        Result = sa + sb;
        C      = ucarry[16];
        // 16-bit signed overflow: the exact 17-bit sum does not fit 16 bits
        V      = Result[16] ^ Result[15];
      end
      OP_SUB: begin
        Result = sa - sb;
        C      = (A < B);
        V      = Result[16] ^ Result[15];
      end
      OP_MUL: Result = sa * sb;
      OP_DIV: begin
        if (B != 16'd0) begin
          Result    = sa / sb;
          Remainder = 16'(sa % sb);
        end
      end
      default: ;
    endcase
  end

  assign Z     = (Result == 32'd0);
  assign N     = Result[31];
  assign C_out = ucarry[16];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-port round-robin issue controller that sequences commands through enhanced_ALU
// and returns tagged results on a valid/ready response port.
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [15:0] rsp_rem,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic        rsp_id_d, rsp_err_d;
  logic [31:0] rsp_result_d;
  logic [15:0] rsp_rem_d;
  logic [3:0]  rsp_flags_d;

  logic        grant1, grant0, accept;
  logic [3:0]  sel_op;
  logic [15:0] sel_a, sel_b, load_cnt;
  logic [31:0] alu_result;
  logic [15:0] alu_rem;
  logic        alu_z, alu_n, alu_c, alu_v, unused_cout;

  enhanced_ALU u_alu (
    .A        (a_q),
    .B        (b_q),
    .operation(op_q),
    .Result   (alu_result),
    .Remainder(alu_rem),
    .Z        (alu_z),
    .N        (alu_n),
    .C        (alu_c),
    .V        (alu_v),
    .C_out    (unused_cout)
  );

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant1     = req1_valid && (!req0_valid || !last_q);
  assign grant0     = req0_valid && !grant1;
  assign req0_ready = !rst && (state_q == StIdle) && grant0;
  assign req1_ready = !rst && (state_q == StIdle) && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  always_comb begin
    load_cnt = 16'd0;
    if (sel_op == OP_MUL)      load_cnt = 16'(MUL_LAT - 1);
    else if (sel_op == OP_DIV) load_cnt = 16'(DIV_LAT - 1);
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id;
    rsp_err_d    = rsp_err;
    rsp_result_d = rsp_result;
    rsp_rem_d    = rsp_rem;
    rsp_flags_d  = rsp_flags;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = sel_op;
          a_d    = sel_a;
          b_d    = sel_b;
          id_d   = grant1;
          last_d = grant1;
          if (cmd_err(sel_op, sel_b)) begin
            state_d      = StResp;
            rsp_id_d     = grant1;
            rsp_err_d    = 1'b1;
            rsp_result_d = 32'd0;
            rsp_rem_d    = 16'd0;
            rsp_flags_d  = 4'd0;
          end else begin
            state_d = StExec;
            cnt_d   = load_cnt;
          end
        end
      end
      StExec: begin
        if (cnt_q == 16'd0) begin
          state_d              = StResp;
          rsp_id_d             = id_q;
          rsp_err_d            = 1'b0;
          rsp_result_d         = alu_result;
          rsp_rem_d            = alu_rem;
          rsp_flags_d[FLAG_Z]  = alu_z;
          rsp_flags_d[FLAG_N]  = alu_n;
          rsp_flags_d[FLAG_C]  = alu_c;
          rsp_flags_d[FLAG_V]  = alu_v;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      cnt_q      <= 16'd0;
      op_q       <= 4'd0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_result <= 32'd0;
      rsp_rem    <= 16'd0;
      rsp_flags  <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_id     <= rsp_id_d;
      rsp_err    <= rsp_err_d;
      rsp_result <= rsp_result_d;
      rsp_rem    <= rsp_rem_d;
      rsp_flags  <= rsp_flags_d;
    end
  end

endmodule
